// File: rtl/mem_ctr2_responder.sv
// Main-memory responder on bus 2: serves whole-line reads and writes from the cache
// after a fixed access latency, moving lines as bursts of 16-bit words.
module mem_ctr2_responder #(
    parameter int MEM_SIZE        = 524288,
    parameter int CACHE_LINE_SIZE = 16,
    parameter int ADDR2_BUS_SIZE  = 15,
    parameter int DATA2_BUS_SIZE  = 16,
    parameter int CTR2_BUS_SIZE   = 2,
    parameter int MEM_LATENCY     = 100
) (
    input  logic                      clk,
    input  logic                      RESET,
    input  logic [ADDR2_BUS_SIZE-1:0] A2,
    inout  wire  [DATA2_BUS_SIZE-1:0] D2,
    inout  wire  [CTR2_BUS_SIZE-1:0]  C2
);
    localparam int N      = CACHE_LINE_SIZE / 2;
    localparam int LINES  = MEM_SIZE / CACHE_LINE_SIZE;
    localparam int DW     = DATA2_BUS_SIZE;
    localparam int LINE_W = N * DW;
    localparam int CNT_W  = $clog2(MEM_LATENCY + N) + 1;
    localparam int IDX_W  = (N > 1) ? $clog2(N) : 1;

    localparam logic [CTR2_BUS_SIZE-1:0] C2_RESPONSE   = CTR2_BUS_SIZE'(1);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_READ_LINE  = CTR2_BUS_SIZE'(2);
    localparam logic [CTR2_BUS_SIZE-1:0] C2_WRITE_LINE = CTR2_BUS_SIZE'(3);

    typedef enum logic [2:0] {IDLE, RD_WAIT, RD_SEND, WR_RECV, WR_WAIT, WR_ACK} state_t;

    state_t                     state_reg, state_next;
    logic [CNT_W-1:0]           cnt_reg, cnt_next;
    logic [ADDR2_BUS_SIZE-1:0]  addr_reg;
    logic [DW-1:0]              line_buf_reg [N];
    logic [LINE_W-1:0]          line_buf_flat;
    logic [LINE_W-1:0]          rd_line_reg;
    logic [DW-1:0]              rd_word [N];
    logic [LINE_W-1:0]          mem [LINES];
    logic                       drive_c2, drive_d2;
    logic [IDX_W-1:0]           word_idx;

    // cnt_reg holds the number of cycles elapsed since the command edge.
    always_ff @(posedge clk) begin
        if (RESET) begin
            state_reg <= IDLE;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg + CNT_W'(1);
        case (state_reg)
            IDLE: begin
                cnt_next = '0;
                if (C2 == C2_READ_LINE) begin
                    state_next = RD_WAIT;
                    cnt_next   = CNT_W'(1);
                end else if (C2 == C2_WRITE_LINE) begin
                    state_next = WR_RECV;
                    cnt_next   = CNT_W'(1);
                end
            end
            RD_WAIT: if (cnt_reg == CNT_W'(MEM_LATENCY - 1)) state_next = RD_SEND;
            RD_SEND: if (cnt_reg == CNT_W'(MEM_LATENCY + N - 1)) state_next = IDLE;
            // With MEM_LATENCY == N+1 there is no time left to wait after the last word.
            WR_RECV: if (cnt_reg == CNT_W'(N))
                         state_next = (N >= MEM_LATENCY - 1) ? WR_ACK : WR_WAIT;
            WR_WAIT: if (cnt_reg == CNT_W'(MEM_LATENCY - 1)) state_next = WR_ACK;
            WR_ACK:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        drive_c2 = 1'b0;
        drive_d2 = 1'b0;
        word_idx = '0;
        case (state_reg)
            RD_SEND: begin
                drive_c2 = 1'b1;
                drive_d2 = 1'b1;
                word_idx = IDX_W'(cnt_reg - CNT_W'(MEM_LATENCY));
            end
            WR_ACK:  drive_c2 = 1'b1;
            default: ;
        endcase
    end

    // Reset releases the bus combinationally so it is already Z in the reset cycle.
    assign C2 = (drive_c2 && !RESET) ? C2_RESPONSE : {CTR2_BUS_SIZE{1'bz}};
    assign D2 = (drive_d2 && !RESET) ? rd_word[word_idx] : {DW{1'bz}};

    always_ff @(posedge clk) begin
        if (state_reg == IDLE && !RESET)
            addr_reg <= A2;
        for (int k = 0; k < N; k++)
            if (state_reg == WR_RECV && cnt_reg == CNT_W'(k + 1))
                line_buf_reg[k] <= D2;
    end

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_words
            assign line_buf_flat[gi*DW +: DW] = line_buf_reg[gi];
            assign rd_word[gi]                = rd_line_reg[gi*DW +: DW];
        end
    endgenerate

    // Whole-line commit happens on the acknowledge edge; an aborted write never gets here.
    always_ff @(posedge clk) begin
        if (state_reg == WR_ACK && !RESET)
            mem[addr_reg] <= line_buf_flat;
        rd_line_reg <= mem[addr_reg];
    end
endmodule

// File: doc/mem_ctr2_responder.md
Name: mem_ctr2_responder

Overview:
Responder end of the cache-to-memory bus (bus 2: A2/D2/C2). Holds main-memory contents. Accepts line read and line write commands from the cache controller. Models a fixed access latency and moves whole lines as bursts of 16-bit words. Sits below the cache in the memory hierarchy as the only other agent on bus 2.

Parameters:
MEM_SIZE, 524288, memory size in bytes; must equal 2^ADDR2_BUS_SIZE * CACHE_LINE_SIZE.
CACHE_LINE_SIZE, 16, line size in bytes; even; N = CACHE_LINE_SIZE/2 words per line.
ADDR2_BUS_SIZE, 15, line-address width (tag+set).
DATA2_BUS_SIZE, 16, data bus width; fixed at 16.
CTR2_BUS_SIZE, 2, command bus width.
MEM_LATENCY, 100, cycles from command acceptance to first response; must be > N.

Ports:
clk  input  1  clock; all sampling and driving on posedge.
RESET  input  1  synchronous, active-high reset.
A2  input  ADDR2_BUS_SIZE  line address; valid in the command cycle.
D2  inout  DATA2_BUS_SIZE  data; driven only while sending read words, Z otherwise.
C2  inout  CTR2_BUS_SIZE  command/response; driven only during response cycles, Z otherwise.

Behaviour:
- C2 encodings: C2_NOP=0, C2_RESPONSE=1, C2_READ_LINE=2, C2_WRITE_LINE=3.
- Array layout: word k of line L = {byte[L*CACHE_LINE_SIZE+2k+1], byte[L*CACHE_LINE_SIZE+2k]} (little-endian).
- Array contents are not touched by RESET.
- Reset: state=IDLE, counters=0, D2/C2 drive enables=0 (both Z). Takes effect in the cycle RESET is high.
- States: IDLE, RD_WAIT, RD_SEND, WR_RECV, WR_WAIT, WR_ACK.
- IDLE:
  - C2==READ_LINE at posedge T: latch A2, cnt=1, go RD_WAIT.
  - C2==WRITE_LINE at T: latch A2, cnt=1, go WR_RECV.
  - NOP/RESPONSE/X/Z: stay IDLE.
- RD_WAIT: cnt++ each cycle. At cycle T+MEM_LATENCY, go RD_SEND.
- RD_SEND: drive C2=RESPONSE and D2=word 0 at T+MEM_LATENCY, then word k at T+MEM_LATENCY+k, for k=0..N-1 (N consecutive cycles, C2 held at RESPONSE). Next cycle release both buses and return to IDLE.
- WR_RECV: sample D2 at T+1..T+N into line buffer word 0..N-1 (word 0 first), then go WR_WAIT.
- WR_WAIT: count until T+MEM_LATENCY-1, then go WR_ACK.
- WR_ACK, at T+MEM_LATENCY:
  - commit the whole line buffer to the array in one step;
  - drive C2=RESPONSE for exactly one cycle, D2 stays Z;
  - release next cycle and return to IDLE.
- Commands that arrive while not IDLE are ignored; no queuing. The earliest new command is accepted in the cycle after release.
- Turnaround: the responder never drives C2/D2 in the command cycle or the cycle after it. The cache has released the bus by T+1.
- Read after write to the same line returns the committed data, since the commit happens before IDLE.
- RESET mid-operation: abort immediately and release the bus. A partially received write line is discarded, so the array is unchanged. A partially sent read ends with no further words.
- RESET and a command in the same cycle: reset wins and the command is dropped.
- Counter width: clog2(MEM_LATENCY+N)+1 bits; no wrap within a transaction.

Test Plan:
Use overrides CACHE_LINE_SIZE=16 (N=8), MEM_LATENCY=10 for all scenarios.
1. Reset: hold RESET 2 cycles, C2=NOP -> C2 and D2 both Z; no response for 20 cycles.
2. Write then read:
   - WRITE_LINE A2=0x0005 at T, D2=0x1100,0x3322,...,0xFFEE over T+1..T+8 -> single RESPONSE at T+10 with D2=Z.
   - READ_LINE A2=0x0005 at T' -> RESPONSE at T'+10..T'+17, D2=0x1100 first through 0xFFEE last; Z at T'+18.
   - Byte check: byte 0x50=0x00, byte 0x51=0x11.
3. Busy ignore: READ_LINE A2=1 at T, then WRITE_LINE A2=2 driven at T+3 -> only the read response occurs; line 2 is unchanged.
4. Reset mid-write: WRITE_LINE A2=7 with 4 words, RESET at T+5 -> no RESPONSE; a later READ_LINE A2=7 returns the original contents.
5. Reset mid-read: RESET at T'+12 during a burst -> C2/D2 are Z from T'+12; the next READ_LINE is served normally with full latency.
6. Back-to-back: a read completes at T+17; READ_LINE at T+18 -> accepted, response at T+28.
